// File: rtl/util_avl2fifo_mc_pkg.sv
// Shared types and sizing helpers for the Avalon-ST to FIFO-write adapter.
package util_avl2fifo_mc_pkg;

  // Alignment state machine: wait for sync, count down the sync delay, then release beats.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Width of the sync-delay down-counter (SYNC_DLY is 1..15).
  localparam int SYNC_CNT_W = 4;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Ring pointers address 0..depth-1; keep at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/util_avl2fifo_mc_if.sv
// Bundle of the Avalon-ST input, FIFO-writer strobes and the write-side outputs.
interface util_avl2fifo_mc_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4
);
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din_data;
  logic [NUM_LANES-1:0]  din_enable;
  logic                  din_ready;
  logic                  din_wr_en;
  logic                  din_wr_sync;
  logic                  dout_valid;
  logic [DATA_WIDTH-1:0] dout_data;
  logic [NUM_LANES-1:0]  dout_enable;
  logic                  dout_wr_ready;
  logic                  dout_wr_en;
  logic                  dout_aligned;
  logic                  underrun;

  // Source side: produces beats and writer strobes, observes the adapter outputs.
  modport master (
    output din_valid, din_data, din_enable, din_wr_en, din_wr_sync,
    input  din_ready, dout_valid, dout_data, dout_enable,
    input  dout_wr_ready, dout_wr_en, dout_aligned, underrun
  );

  // Adapter side.
  modport slave (
    input  din_valid, din_data, din_enable, din_wr_en, din_wr_sync,
    output din_ready, dout_valid, dout_data, dout_enable,
    output dout_wr_ready, dout_wr_en, dout_aligned, underrun
  );
endinterface

// File: rtl/util_dly_line.sv
// Zero-reset shift register; exposes one intermediate stage (TAP, 0 = input) and the last stage.
module util_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter int TAP   = DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH:1][WIDTH-1:0] stage_reg;

  // Advance every stage by one cycle; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[1] <= din;
      for (int i = 2; i <= DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  generate
    if (TAP == 0) begin : g_tap_in
      assign tap = din;
    end else begin : g_tap_stage
      assign tap = stage_reg[TAP];
    end
  endgenerate

  assign dout = stage_reg[DEPTH];
endmodule

// File: rtl/util_avl2fifo_mc.sv
// Avalon-ST to FIFO-write adapter: ring buffer released after write-sync, with
// write-enable/ready strobes delayed to match the downstream pipeline.
module util_avl2fifo_mc
  import util_avl2fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4,
  parameter int DEPTH      = 4,
  parameter int SYNC_DLY   = 3,
  parameter int PIPE_DLY   = 6,
  parameter int READY_ADV  = 1
) (
  input logic              clk,
  input logic              rst,
  util_avl2fifo_mc_if.slave bus
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int K     = PIPE_DLY - READY_ADV;
  localparam logic [SYNC_CNT_W-1:0] SYNC_LOAD = SYNC_CNT_W'(SYNC_DLY - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_LANES-1:0]  enable;
  } beat_t;

  beat_t                 ring_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  state_e                state_reg, state_next;
  logic [SYNC_CNT_W-1:0] sync_cnt_reg, sync_cnt_next;
  logic                  underrun_reg;

  logic  sync_evt, run, ring_empty, ring_full, push, pop, full_at_pop;
  beat_t head;
  logic  v_k, v_k1, v_p, v_p1, f_k, f_p;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign sync_evt   = bus.din_wr_en & bus.din_wr_sync;
  assign run        = (state_reg == RUN);
  assign ring_empty = (count_reg == '0);
  assign ring_full  = (count_reg == CNT_W'(DEPTH));
  assign push       = bus.din_valid & ~ring_full;
  assign pop        = run & bus.din_wr_en & ~ring_empty;
  assign head       = ring_reg[rd_ptr_reg];

  // Write side of the ring: store accepted beats and advance the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_reg[i] <= '0;
      wr_ptr_reg <= '0;
    end else if (push) begin
      ring_reg[wr_ptr_reg] <= '{data: bus.din_data, enable: bus.din_enable};
      wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Alignment FSM state and sync-delay counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sync_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      sync_cnt_reg <= sync_cnt_next;
    end
  end

  // Next state: a sync always (re)starts alignment; ALIGN enters RUN when the count reaches zero.
  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sync_evt) begin
          state_next    = ALIGN;
          sync_cnt_next = SYNC_LOAD;
        end
      end
      ALIGN: begin
        if (sync_evt) begin
          sync_cnt_next = SYNC_LOAD;
        end else if (sync_cnt_reg <= SYNC_CNT_W'(1)) begin
          state_next    = RUN;
          sync_cnt_next = '0;
        end else begin
          sync_cnt_next = sync_cnt_reg - SYNC_CNT_W'(1);
        end
      end
      RUN: begin
        if (sync_evt) begin
          state_next    = ALIGN;
          sync_cnt_next = SYNC_LOAD;
        end
      end
      default: begin
        state_next    = IDLE;
        sync_cnt_next = '0;
      end
    endcase
  end

  // Sticky underrun: writer asked for a beat in RUN with nothing buffered; a sync clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_reg <= 1'b0;
    end else if (sync_evt) begin
      underrun_reg <= 1'b0;
    end else if (bus.din_wr_en && run && ring_empty) begin
      underrun_reg <= 1'b1;
    end
  end

  // Pop history: stages K..K+1 feed the early ready, stages PIPE_DLY..PIPE_DLY+1 the write enable.
  assign full_at_pop = pop & (&head.enable);

  util_dly_line #(.WIDTH(1), .DEPTH(K + 1), .TAP(K)) u_v_dly (
    .clk(clk), .rst(rst), .din(pop), .tap(v_k), .dout(v_k1)
  );

  generate
    if (READY_ADV == 0) begin : g_no_adv
      assign v_p  = v_k;
      assign v_p1 = v_k1;
    end else begin : g_adv
      util_dly_line #(.WIDTH(1), .DEPTH(READY_ADV), .TAP(READY_ADV - 1)) u_v_dly_late (
        .clk(clk), .rst(rst), .din(v_k1), .tap(v_p), .dout(v_p1)
      );
    end
  endgenerate

  // Full-lane flag of each pop; a partial beat takes the one-cycle-longer path.
  util_dly_line #(.WIDTH(1), .DEPTH(PIPE_DLY), .TAP(K)) u_f_dly (
    .clk(clk), .rst(rst), .din(full_at_pop), .tap(f_k), .dout(f_p)
  );

  assign bus.din_ready     = ~rst & ~ring_full;
  assign bus.dout_valid    = run & ~ring_empty;
  assign bus.dout_data     = (run & ~ring_empty) ? head.data : '0;
  assign bus.dout_enable   = (run & ~ring_empty) ? head.enable : '0;
  assign bus.dout_wr_en    = bus.din_wr_en & (f_p ? v_p : v_p1);
  assign bus.dout_wr_ready = f_k ? v_k : v_k1;
  assign bus.dout_aligned  = run;
  assign bus.underrun      = underrun_reg;
endmodule

// File: tb/tb_util_avl2fifo_mc.sv
// Directed bench for util_avl2fifo_mc with default parameters.
module tb_util_avl2fifo_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [63:0] d_dat [5];
  logic [3:0]  d_en  [5];
  logic [63:0] e_dat [6];

  always #5 clk = ~clk;

  util_avl2fifo_mc_if #(.DATA_WIDTH(64), .NUM_LANES(4)) bus ();

  util_avl2fifo_mc #(
    .DATA_WIDTH(64), .NUM_LANES(4), .DEPTH(4),
    .SYNC_DLY(3), .PIPE_DLY(6), .READY_ADV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total_cnt++; if (bus.din_ready !== 1'b0) $display("FAIL reset_din_ready: got %b expected 0", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== 64'h0) $display("FAIL reset_dout_data: got %h expected 0", bus.dout_data); else pass_cnt++;
    total_cnt++; if (bus.dout_enable !== 4'h0) $display("FAIL reset_dout_enable: got %h expected 0", bus.dout_enable); else pass_cnt++;
    total_cnt++; if (bus.dout_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", bus.dout_wr_en); else pass_cnt++;
    total_cnt++; if (bus.dout_wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b expected 0", bus.dout_wr_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_aligned !== 1'b0) $display("FAIL reset_aligned: got %b expected 0", bus.dout_aligned); else pass_cnt++;
    total_cnt++; if (bus.underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", bus.underrun); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b1) $display("FAIL release_din_ready: got %b expected 1", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL release_dout_valid: got %b expected 0", bus.dout_valid); else pass_cnt++;
    tick();
  endtask

  // Five beats into a four-entry ring before any sync: the fifth is held off.
  task automatic test_fill();
    logic exp_rdy;
    for (int i = 0; i < 5; i++) begin
      bus.din_valid  = 1'b1;
      bus.din_data   = d_dat[i];
      bus.din_enable = d_en[i];
      #1;
      exp_rdy = (i < 4) ? 1'b1 : 1'b0;
      total_cnt++; if (bus.din_ready !== exp_rdy) $display("FAIL fill_din_ready[%0d]: got %b expected %b", i, bus.din_ready, exp_rdy); else pass_cnt++;
      tick();
    end
    bus.din_valid = 1'b0;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b0) $display("FAIL full_din_ready: got %b expected 0", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL fill_dout_valid: got %b expected 0", bus.dout_valid); else pass_cnt++;
  endtask

  // Sync at T, aligned at T+3; pop D0 at P, ready at P+5, wr_en at P+6 (while popping D1).
  task automatic test_sync();
    logic exp_al;
    bus.din_wr_en = 1'b1; bus.din_wr_sync = 1'b1;
    #1;
    total_cnt++; if (bus.dout_aligned !== 1'b0) $display("FAIL sync_aligned_T0: got %b expected 0", bus.dout_aligned); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0; bus.din_wr_sync = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      exp_al = (k == 3) ? 1'b1 : 1'b0;
      total_cnt++; if (bus.dout_aligned !== exp_al) $display("FAIL sync_aligned_T%0d: got %b expected %b", k, bus.dout_aligned, exp_al); else pass_cnt++;
      if (k < 3) tick();
    end
    total_cnt++; if (bus.dout_valid !== 1'b1) $display("FAIL run_dout_valid: got %b expected 1", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== d_dat[0]) $display("FAIL pop_d0_data: got %h expected %h", bus.dout_data, d_dat[0]); else pass_cnt++;
    bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.dout_enable !== 4'hf) $display("FAIL pop_d0_enable: got %h expected f", bus.dout_enable); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      #1;
      if (j == 4) begin
        total_cnt++; if (bus.dout_wr_ready !== 1'b0) $display("FAIL wr_ready_P4: got %b expected 0", bus.dout_wr_ready); else pass_cnt++;
      end
      if (j == 5) begin
        total_cnt++; if (bus.dout_wr_ready !== 1'b1) $display("FAIL wr_ready_P5: got %b expected 1", bus.dout_wr_ready); else pass_cnt++;
      end
      tick();
    end
    bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b1) $display("FAIL wr_en_P6: got %b expected 1", bus.dout_wr_en); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== d_dat[1]) $display("FAIL pop_d1_data: got %h expected %h", bus.dout_data, d_dat[1]); else pass_cnt++;
    total_cnt++; if (bus.dout_enable !== 4'h7) $display("FAIL pop_d1_enable: got %h expected 7", bus.dout_enable); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0;
  endtask

  // D1 (partial, popped at Q) writes at Q+7; D2 (full, popped at R) writes at R+6.
  task automatic test_partial();
    repeat (5) tick();
    bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b0) $display("FAIL partial_wr_en_Q6: got %b expected 0", bus.dout_wr_en); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== d_dat[2]) $display("FAIL pop_d2_data: got %h expected %h", bus.dout_data, d_dat[2]); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b1) $display("FAIL partial_wr_en_Q7: got %b expected 1", bus.dout_wr_en); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== d_dat[3]) $display("FAIL pop_d3_data: got %h expected %h", bus.dout_data, d_dat[3]); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0;
    repeat (3) tick();
    bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b0) $display("FAIL full_wr_en_R5: got %b expected 0", bus.dout_wr_en); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL empty_dout_valid: got %b expected 0", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.underrun !== 1'b0) $display("FAIL underrun_before: got %b expected 0", bus.underrun); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b1) $display("FAIL full_wr_en_R6: got %b expected 1", bus.dout_wr_en); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.dout_wr_en !== 1'b1) $display("FAIL d3_wr_en_R7: got %b expected 1", bus.dout_wr_en); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0;
  endtask

  // Underrun raised by slot strobes on an empty ring, sticky until the next sync.
  task automatic test_underrun();
    #1;
    total_cnt++; if (bus.underrun !== 1'b1) $display("FAIL underrun_set: got %b expected 1", bus.underrun); else pass_cnt++;
    tick();
    total_cnt++; if (bus.underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", bus.underrun); else pass_cnt++;
    bus.din_wr_en = 1'b1; bus.din_wr_sync = 1'b1;
    tick();
    bus.din_wr_en = 1'b0; bus.din_wr_sync = 1'b0;
    #1;
    total_cnt++; if (bus.underrun !== 1'b0) $display("FAIL underrun_clear: got %b expected 0", bus.underrun); else pass_cnt++;
    total_cnt++; if (bus.dout_aligned !== 1'b0) $display("FAIL resync_aligned_S1: got %b expected 0", bus.dout_aligned); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.dout_aligned !== 1'b1) $display("FAIL resync_aligned_S3: got %b expected 1", bus.dout_aligned); else pass_cnt++;
  endtask

  // Push and pop together, pop at full, then a reset pulse with write strobes in flight.
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1; bus.din_data = e_dat[i]; bus.din_enable = 4'hf;
      #1;
      total_cnt++; if (bus.din_ready !== 1'b1) $display("FAIL b2b_push_ready[%0d]: got %b expected 1", i, bus.din_ready); else pass_cnt++;
      tick();
    end
    bus.din_data = e_dat[3]; bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.dout_data !== e_dat[0]) $display("FAIL b2b_head_e0: got %h expected %h", bus.dout_data, e_dat[0]); else pass_cnt++;
    tick();
    bus.din_data = e_dat[4]; bus.din_wr_en = 1'b0;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b1) $display("FAIL b2b_count_kept: got %b expected 1", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== e_dat[1]) $display("FAIL b2b_head_e1: got %h expected %h", bus.dout_data, e_dat[1]); else pass_cnt++;
    tick();
    bus.din_data = e_dat[5]; bus.din_wr_en = 1'b1;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", bus.din_ready); else pass_cnt++;
    tick();
    bus.din_valid = 1'b0;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b1) $display("FAIL b2b_after_pop_ready: got %b expected 1", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_data !== e_dat[2]) $display("FAIL b2b_head_e2: got %h expected %h", bus.dout_data, e_dat[2]); else pass_cnt++;
    tick();
    bus.din_wr_en = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.din_ready !== 1'b0) $display("FAIL midrst_din_ready: got %b expected 0", bus.din_ready); else pass_cnt++;
    total_cnt++; if (bus.dout_valid !== 1'b0) $display("FAIL midrst_dout_valid: got %b expected 0", bus.dout_valid); else pass_cnt++;
    total_cnt++; if (bus.dout_aligned !== 1'b0) $display("FAIL midrst_aligned: got %b expected 0", bus.dout_aligned); else pass_cnt++;
    tick();
    rst = 1'b0;
    bus.din_wr_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total_cnt++; if ({bus.dout_wr_en, bus.dout_wr_ready} !== 2'b00) $display("FAIL postrst_strobes[%0d]: got %b expected 00", c, {bus.dout_wr_en, bus.dout_wr_ready}); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.underrun !== 1'b0) $display("FAIL postrst_underrun: got %b expected 0", bus.underrun); else pass_cnt++;
    bus.din_wr_en = 1'b0;
    bus.din_valid = 1'b1; bus.din_data = 64'h0123_4567_89ab_cdef; bus.din_enable = 4'h3;
    tick();
    bus.din_valid = 1'b0;
    bus.din_wr_en = 1'b1; bus.din_wr_sync = 1'b1;
    tick();
    bus.din_wr_en = 1'b0; bus.din_wr_sync = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.dout_data !== 64'h0123_4567_89ab_cdef) $display("FAIL postrst_head_data: got %h expected 0123456789abcdef", bus.dout_data); else pass_cnt++;
    total_cnt++; if (bus.dout_enable !== 4'h3) $display("FAIL postrst_head_enable: got %h expected 3", bus.dout_enable); else pass_cnt++;
  endtask

  initial begin
    bus.din_valid   = 1'b0;
    bus.din_data    = '0;
    bus.din_enable  = '0;
    bus.din_wr_en   = 1'b0;
    bus.din_wr_sync = 1'b0;
    for (int i = 0; i < 5; i++) d_dat[i] = 64'hd0d0_0000_0000_0000 + 64'(i * 17 + 1);
    d_en[0] = 4'hf; d_en[1] = 4'h7; d_en[2] = 4'hf; d_en[3] = 4'hf; d_en[4] = 4'hf;
    for (int i = 0; i < 6; i++) e_dat[i] = 64'he0e0_0000_0000_0000 + 64'(i * 257 + 3);

    test_reset();
    test_fill();
    test_sync();
    test_partial();
    test_underrun();
    test_back_to_back();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
